game_ctrl_param: RTL and testbench
==================================

Name: game_ctrl_param

Overview:
- Parametrised game-sequencing FSM for the factorization quiz: READY -> QUESTION -> INPUT -> result display -> READY.
- Generalised over the fixed 1-s controller in four ways:
  - configurable result-hold time;
  - answer timeout that penalises the player;
  - wrong-attempt limit that converts repeated WRONG into OUCH;
  - round counter.
- Sits between the button debouncers and judge/HP logic upstream and the display/LED drivers downstream.

Parameters:
- HOLD_CYC, 50_000_000: cycles each result state (WRONG/GOOD/OUCH/DRAW/WIN/LOSE) is held; 1 s at 50 MHz.
- TIMEOUT_CYC, 500_000_000: cycles allowed in INPUT before forced OUCH.
- MAX_WRONG, 3: WRONG_IN events per question before forced OUCH; must be 1..15.
- SEL_W, 3: width of SEL_IN/SEL_OUT.
- ROUND_W, 4: width of ROUND.

Ports:
- CLK in 1: system clock.
- RST in 1: synchronous, active-high reset.
- START in 1: 1-cycle pulse; begin question from READY.
- QUE_IN in 1: 1-cycle pulse; toggles between question view and answer entry.
- SEL_IN in SEL_W: digit select from keypad.
- DEC_IN in 1: decrement request.
- CLR_IN in 1: clear request.
- WRONG_IN in 1: 1-cycle pulse; malformed answer.
- JUDG_IN in 2: judge result; 00 none, 01 good, 10 ouch, 11 draw.
- HP_IN in 2: HP status; 00 alive, 01 opponent dead, 10 player dead.
- STATE out 4: current state code.
- SEL_OUT out SEL_W: SEL_IN sampled in INPUT.
- DEC_OUT out 1: DEC_IN sampled in INPUT.
- CLR_OUT out 1: CLR_IN sampled in INPUT.
- ROUND out ROUND_W: completed rounds in current game.
- WRONG_CNT out 4: wrong attempts on current question.
- TIMEOUT out 1: high while in OUCH entered by timeout.

Behaviour:
- Codes: READY 0010, QUESTION 0011, INPUT 0100, DRAW 0110, WRONG 0111, GOOD 1000, OUCH 1001, WIN 1010, LOSE 1011.
- STATE is the state register itself; no extra cycle lag. Unused codes recover to READY on the next cycle.
- RST, sampled on posedge CLK:
  - STATE=READY; SEL_OUT=0, DEC_OUT=0, CLR_OUT=0; ROUND=0, WRONG_CNT=0, TIMEOUT=0.
  - Hold counter and timeout counter = 0.
  - RST overrides all inputs, including mid-hold or mid-INPUT.
- READY: START=1 -> QUESTION next cycle; timeout counter and WRONG_CNT cleared.
- QUESTION: QUE_IN=1 -> INPUT. Timeout counter frozen.
- INPUT, priority order:
  1. QUE_IN -> QUESTION; timeout counter keeps its value.
  2. WRONG_IN -> WRONG_CNT+1. If new count == MAX_WRONG -> OUCH, else -> WRONG.
  3. JUDG_IN: 01 -> GOOD; 10 -> OUCH; 11 -> DRAW.
  4. Timeout counter == TIMEOUT_CYC-1 -> OUCH, set TIMEOUT=1.
  5. Otherwise stay; timeout counter +1.
- SEL_OUT/DEC_OUT/CLR_OUT register their inputs every cycle STATE==INPUT and hold their last value in all other states.
- Hold states:
  - Hold counter clears on every state change and increments each cycle in the hold state.
  - Exit fires on the cycle the counter == HOLD_CYC-1, so each state is visible exactly HOLD_CYC cycles absent overrides.
- WRONG: on expiry -> INPUT; timeout counter frozen during WRONG; WRONG_CNT kept.
- GOOD: HP_IN==01 on any cycle before expiry -> WIN; hold restarts in WIN. On expiry -> READY with ROUND+1.
- OUCH: HP_IN==10 before expiry -> LOSE. On expiry -> READY with ROUND+1.
- HP_IN on the expiry cycle itself: expiry wins.
- DRAW: on expiry -> READY with ROUND+1.
- ROUND saturates at all-ones.
- WIN/LOSE: on expiry -> READY with ROUND=0 (new game).
- TIMEOUT clears on leaving OUCH, including via the OUCH->LOSE path.
- Pulse inputs (START, QUE_IN, WRONG_IN) are ignored in states where they are not listed.
- JUDG_IN and HP_IN are level inputs, sampled only where listed.

Test Plan (HOLD_CYC=4, TIMEOUT_CYC=20, MAX_WRONG=2):
- Happy path: RST; START; QUE_IN; JUDG_IN=01 for 1 cycle -> STATE 0010,0011,0100,1000. Stays 1000 for exactly 4 cycles, then 0010 with ROUND=1.
- Wrong limit: in INPUT pulse WRONG_IN -> 0111 for 4 cycles, back to 0100, WRONG_CNT=1. Second WRONG_IN -> 1001 directly, WRONG_CNT=2; next question from READY shows WRONG_CNT=0.
- Timeout with pause:
  - enter INPUT, wait 10 cycles, QUE_IN to QUESTION for 30 cycles, QUE_IN back;
  - OUCH with TIMEOUT=1 after exactly 10 further INPUT cycles;
  - TIMEOUT=0 once STATE returns to 0010.
- HP override: GOOD with HP_IN=01 asserted on hold cycle 2 -> 1010 for 4 cycles -> 0010, ROUND=0. OUCH with HP_IN=10 on hold cycle 3 (expiry) -> 0010, not 1011.
- Simultaneous events and capture:
  - QUE_IN, WRONG_IN and JUDG_IN=01 in the same INPUT cycle -> QUESTION, WRONG_CNT unchanged.
  - SEL_IN changes outside INPUT leave SEL_OUT unchanged.
- Reset mid-hold: RST asserted in DRAW hold cycle 1 -> READY next edge, all outputs at reset values; ROUND saturation check with ROUND_W=2 after 5 DRAW rounds -> ROUND=3.

Source files
------------

// File: rtl/game_ctrl_param.sv
// Game-sequencing FSM for the factorization quiz with configurable result hold,
// answer timeout, wrong-attempt limit and a saturating round counter.
module game_ctrl_param #(
  parameter int HOLD_CYC    = 50_000_000,
  parameter int TIMEOUT_CYC = 500_000_000,
  parameter int MAX_WRONG   = 3,
  parameter int SEL_W       = 3,
  parameter int ROUND_W     = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               QUE_IN,
  input  logic [SEL_W-1:0]   SEL_IN,
  input  logic               DEC_IN,
  input  logic               CLR_IN,
  input  logic               WRONG_IN,
  input  logic [1:0]         JUDG_IN,
  input  logic [1:0]         HP_IN,
  output logic [3:0]         STATE,
  output logic [SEL_W-1:0]   SEL_OUT,
  output logic               DEC_OUT,
  output logic               CLR_OUT,
  output logic [ROUND_W-1:0] ROUND,
  output logic [3:0]         WRONG_CNT,
  output logic               TIMEOUT
);

  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [3:0] {
    S_READY    = 4'b0010,
    S_QUESTION = 4'b0011,
    S_INPUT    = 4'b0100,
    S_DRAW     = 4'b0110,
    S_WRONG    = 4'b0111,
    S_GOOD     = 4'b1000,
    S_OUCH     = 4'b1001,
    S_WIN      = 4'b1010,
    S_LOSE     = 4'b1011
  } state_t;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [3:0]         wrong_q, wrong_d;
  logic [ROUND_W-1:0] round_q, round_d, round_inc;
  logic               timeout_q, timeout_d;
  logic               timeout_fire, hold_exp, in_hold;
  logic [SEL_W-1:0]   sel_q;
  logic               dec_q, clr_q;

  // START, QUE_IN and WRONG_IN are single-cycle pulses acted on only in the
  // state that consumes them; JUDG_IN/HP_IN are levels sampled where used.
  assign hold_exp  = (hold_q == HOLD_W'(HOLD_CYC - 1));
  assign in_hold   = state_q inside {S_DRAW, S_WRONG, S_GOOD, S_OUCH, S_WIN, S_LOSE};
  assign round_inc = (round_q == {ROUND_W{1'b1}}) ? round_q : round_q + ROUND_W'(1);

  always_comb begin
    state_d      = state_q;
    to_d         = to_q;
    wrong_d      = wrong_q;
    round_d      = round_q;
    timeout_fire = 1'b0;
    case (state_q)
      S_READY: begin
        if (START) begin
          state_d = S_QUESTION;
          to_d    = '0;
          wrong_d = '0;
        end
      end
      S_QUESTION: if (QUE_IN) state_d = S_INPUT;
      S_INPUT: begin
        if (QUE_IN) begin
          state_d = S_QUESTION;
        end else if (WRONG_IN) begin
          wrong_d = wrong_q + 4'd1;
          state_d = (wrong_d == 4'(MAX_WRONG)) ? S_OUCH : S_WRONG;
        end else if (JUDG_IN == 2'b01) begin
          state_d = S_GOOD;
        end else if (JUDG_IN == 2'b10) begin
          state_d = S_OUCH;
        end else if (JUDG_IN == 2'b11) begin
          state_d = S_DRAW;
        end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
          state_d      = S_OUCH;
          timeout_fire = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_WRONG: if (hold_exp) state_d = S_INPUT;
      // Expiry takes precedence over an HP event arriving on the same cycle.
      S_GOOD: begin
        if (hold_exp) begin
          state_d = S_READY;
          round_d = round_inc;
        end else if (HP_IN == 2'b01) begin
          state_d = S_WIN;
        end
      end
      S_OUCH: begin
        if (hold_exp) begin
          state_d = S_READY;
          round_d = round_inc;
        end else if (HP_IN == 2'b10) begin
          state_d = S_LOSE;
        end
      end
      S_DRAW: begin
        if (hold_exp) begin
          state_d = S_READY;
          round_d = round_inc;
        end
      end
      S_WIN, S_LOSE: begin
        if (hold_exp) begin
          state_d = S_READY;
          round_d = '0;
        end
      end
      default: state_d = S_READY;
    endcase

    if (state_d != state_q) hold_d = '0;
    else if (in_hold)       hold_d = hold_q + HOLD_W'(1);
    else                    hold_d = '0;

    timeout_d = (state_d == S_OUCH) && (timeout_fire || ((state_q == S_OUCH) && timeout_q));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_READY;
      hold_q    <= '0;
      to_q      <= '0;
      wrong_q   <= '0;
      round_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      to_q      <= to_d;
      wrong_q   <= wrong_d;
      round_q   <= round_d;
      timeout_q <= timeout_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sel_q <= '0;
      dec_q <= 1'b0;
      clr_q <= 1'b0;
    end else if (state_q == S_INPUT) begin
      sel_q <= SEL_IN;
      dec_q <= DEC_IN;
      clr_q <= CLR_IN;
    end
  end

  assign STATE     = state_q;
  assign SEL_OUT   = sel_q;
  assign DEC_OUT   = dec_q;
  assign CLR_OUT   = clr_q;
  assign ROUND     = round_q;
  assign WRONG_CNT = wrong_q;
  assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_game_ctrl_param.sv
// Bench for game_ctrl_param: directed test-plan scenarios plus random stimulus,
// every cycle scored against a countdown-based behavioural model.
module tb_game_ctrl_param;

  localparam int HOLD = 4;
  localparam int TOUT = 20;
  localparam int MAXW = 2;
  localparam int SELW = 3;
  localparam int RW   = 2;
  localparam int EW   = 4 + SELW + 1 + 1 + RW + 4 + 1;

  localparam int C_READY = 2, C_QUES = 3, C_INP = 4, C_DRAW = 6, C_WRONG = 7;
  localparam int C_GOOD = 8, C_OUCH = 9, C_WIN = 10, C_LOSE = 11;

  // clock / reset / stimulus signals
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, que = 1'b0, wrong = 1'b0, dec = 1'b0, clr = 1'b0;
  logic [SELW-1:0] sel = '0;
  logic [1:0] judg = 2'b00, hp = 2'b00;

  logic [3:0]      state;
  logic [SELW-1:0] sel_out;
  logic            dec_out, clr_out, timeout;
  logic [RW-1:0]   round;
  logic [3:0]      wrong_cnt;

  always #5 clk = ~clk;

  game_ctrl_param #(
    .HOLD_CYC(HOLD), .TIMEOUT_CYC(TOUT), .MAX_WRONG(MAXW), .SEL_W(SELW), .ROUND_W(RW)
  ) dut (
    .CLK(clk), .RST(rst), .START(start), .QUE_IN(que), .SEL_IN(sel), .DEC_IN(dec),
    .CLR_IN(clr), .WRONG_IN(wrong), .JUDG_IN(judg), .HP_IN(hp), .STATE(state),
    .SEL_OUT(sel_out), .DEC_OUT(dec_out), .CLR_OUT(clr_out), .ROUND(round),
    .WRONG_CNT(wrong_cnt), .TIMEOUT(timeout)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // behavioural model: hold and timeout tracked as remaining-cycle budgets
  int m_state = C_READY, m_hold_left = HOLD, m_budget = TOUT, m_wrong = 0, m_round = 0;
  logic [SELW-1:0] m_sel = '0;
  logic m_dec = 1'b0, m_clr = 1'b0, m_to = 1'b0;

  function automatic bit is_hold(input int s);
    return (s == C_DRAW) || (s == C_WRONG) || (s == C_GOOD) ||
           (s == C_OUCH) || (s == C_WIN) || (s == C_LOSE);
  endfunction

  function automatic int bump_round(input int r);
    return (r == (1 << RW) - 1) ? r : r + 1;
  endfunction

  task automatic model_step();
    int nxt;
    bit fired;
    bit expired;
    if (rst) begin
      m_state = C_READY; m_sel = '0; m_dec = 1'b0; m_clr = 1'b0;
      m_round = 0; m_wrong = 0; m_to = 1'b0; m_hold_left = HOLD; m_budget = TOUT;
    end else begin
      nxt = m_state;
      fired = 1'b0;
      expired = (m_hold_left == 1);
      if (m_state == C_INP) begin
        m_sel = sel; m_dec = dec; m_clr = clr;
      end
      case (m_state)
        C_READY: if (start) begin nxt = C_QUES; m_budget = TOUT; m_wrong = 0; end
        C_QUES:  if (que) nxt = C_INP;
        C_INP: begin
          if (que) nxt = C_QUES;
          else if (wrong) begin
            m_wrong++;
            nxt = (m_wrong == MAXW) ? C_OUCH : C_WRONG;
          end
          else if (judg == 2'b01) nxt = C_GOOD;
          else if (judg == 2'b10) nxt = C_OUCH;
          else if (judg == 2'b11) nxt = C_DRAW;
          else if (m_budget == 1) begin nxt = C_OUCH; fired = 1'b1; end
          else m_budget--;
        end
        C_WRONG: if (expired) nxt = C_INP;
        C_GOOD: begin
          if (expired) begin nxt = C_READY; m_round = bump_round(m_round); end
          else if (hp == 2'b01) nxt = C_WIN;
        end
        C_OUCH: begin
          if (expired) begin nxt = C_READY; m_round = bump_round(m_round); end
          else if (hp == 2'b10) nxt = C_LOSE;
        end
        C_DRAW: if (expired) begin nxt = C_READY; m_round = bump_round(m_round); end
        C_WIN, C_LOSE: if (expired) begin nxt = C_READY; m_round = 0; end
        default: nxt = C_READY;
      endcase
      if (nxt != m_state) m_hold_left = HOLD;
      else if (is_hold(m_state)) m_hold_left--;
      m_to = (nxt == C_OUCH) && (fired || (m_state == C_OUCH && m_to));
      m_state = nxt;
    end
  endtask

  function automatic logic [EW-1:0] pack_model();
    logic [3:0] s4;
    logic [RW-1:0] r;
    logic [3:0] w;
    s4 = 4'(m_state);
    r  = RW'(m_round);
    w  = 4'(m_wrong);
    return {s4, m_sel, m_dec, m_clr, r, w, m_to};
  endfunction

  // driver: one clock of stimulus, model update, and output comparison
  task automatic tick();
    logic [EW-1:0] e;
    model_step();
    exp_q.push_back(pack_model());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("state",     32'(state),     32'(e[EW-1 -: 4]));
    check("sel_out",   32'(sel_out),   32'(e[EW-5 -: SELW]));
    check("dec_out",   32'(dec_out),   32'(e[RW+6]));
    check("clr_out",   32'(clr_out),   32'(e[RW+5]));
    check("round",     32'(round),     32'(e[RW+4:5]));
    check("wrong_cnt", 32'(wrong_cnt), 32'(e[4:1]));
    check("timeout",   32'(timeout),   32'(e[0]));
    rst = 1'b0; start = 1'b0; que = 1'b0; wrong = 1'b0; judg = 2'b00; hp = 2'b00;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic go_input();
    start = 1'b1; tick();
    que = 1'b1;   tick();
  endtask

  initial begin
    // reset
    rst = 1'b1; tick();
    check("rst_state", 32'(state), 32'd2);
    check("rst_round", 32'(round), 32'd0);

    // happy path
    start = 1'b1; tick(); check("happy_q", 32'(state), 32'h3);
    que = 1'b1;   tick(); check("happy_in", 32'(state), 32'h4);
    judg = 2'b01; tick(); check("happy_good", 32'(state), 32'h8);
    ticks(3);             check("happy_hold4", 32'(state), 32'h8);
    tick();               check("happy_ready", 32'(state), 32'h2);
    check("happy_round", 32'(round), 32'd1);

    // wrong limit
    go_input();
    wrong = 1'b1; tick(); check("wrong1", 32'(state), 32'h7);
    check("wrong1_cnt", 32'(wrong_cnt), 32'd1);
    ticks(3); tick();     check("wrong_back", 32'(state), 32'h4);
    wrong = 1'b1; tick(); check("wrong2_ouch", 32'(state), 32'h9);
    check("wrong2_cnt", 32'(wrong_cnt), 32'd2);
    check("wrong2_noto", 32'(timeout), 32'd0);
    ticks(4);
    start = 1'b1; tick(); check("wrong_clear", 32'(wrong_cnt), 32'd0);

    // timeout with pause
    que = 1'b1; tick();
    ticks(10);
    que = 1'b1; tick();   check("pause_q", 32'(state), 32'h3);
    ticks(30);
    que = 1'b1; tick();
    ticks(9);             check("to_still_in", 32'(state), 32'h4);
    tick();               check("to_ouch", 32'(state), 32'h9);
    check("to_flag", 32'(timeout), 32'd1);
    ticks(4);             check("to_ready", 32'(state), 32'h2);
    check("to_flag_clr", 32'(timeout), 32'd0);

    // HP override to WIN, then HP on expiry cycle ignored
    go_input();
    judg = 2'b01; tick(); tick();
    hp = 2'b01; tick();   check("win", 32'(state), 32'ha);
    ticks(3); tick();     check("win_ready", 32'(state), 32'h2);
    check("win_round", 32'(round), 32'd0);
    go_input();
    judg = 2'b10; tick(); ticks(3);
    hp = 2'b10; tick();   check("hp_expiry", 32'(state), 32'h2);

    // timeout OUCH then LOSE clears TIMEOUT
    go_input();
    ticks(TOUT - 1);
    tick();               check("to2_flag", 32'(timeout), 32'd1);
    hp = 2'b10; tick();   check("lose", 32'(state), 32'hb);
    check("lose_to_clr", 32'(timeout), 32'd0);
    ticks(4);

    // simultaneous events and capture
    go_input();
    sel = 3'd6; dec = 1'b1; clr = 1'b0;
    que = 1'b1; wrong = 1'b1; judg = 2'b01; tick();
    check("simul_q", 32'(state), 32'h3);
    check("simul_cnt", 32'(wrong_cnt), 32'd0);
    sel = 3'd1; dec = 1'b0; tick();
    check("sel_hold", 32'(sel_out), 32'd6);
    check("dec_hold", 32'(dec_out), 32'd1);
    que = 1'b1; tick();
    judg = 2'b11; tick(); ticks(4);

    // reset mid-hold
    go_input();
    judg = 2'b11; tick(); tick();
    rst = 1'b1; tick();
    check("rst_mid_state", 32'(state), 32'h2);
    check("rst_mid_sel", 32'(sel_out), 32'd0);
    check("rst_mid_round", 32'(round), 32'd0);

    // round saturation
    for (int r = 0; r < 5; r++) begin
      go_input();
      judg = 2'b11; tick(); ticks(4);
    end
    check("round_sat", 32'(round), 32'd3);

    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 3) == 0);
      que   = ($urandom_range(0, 7) == 0);
      wrong = ($urandom_range(0, 9) == 0);
      judg  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      hp    = 2'($urandom_range(0, 3));
      sel   = SELW'($urandom);
      dec   = 1'($urandom);
      clr   = 1'($urandom);
      tick();
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
